// File: rtl/stream_demux2.sv
// Packet-aware 1-to-2 valid/ready demultiplexer with registered outputs and per-channel packet counters.
// Optional macro STREAM_DEMUX2_INVERT_EN: holding registers capture the bitwise complement of in_data.
module stream_demux2 #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  input  logic                 sel,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [WIDTH-1:0]     out1_data,
  output logic                 out1_last,
  output logic                 out2_valid,
  input  logic                 out2_ready,
  output logic [WIDTH-1:0]     out2_data,
  output logic                 out2_last,
  output logic [CNT_WIDTH-1:0] pkt_cnt1,
  output logic [CNT_WIDTH-1:0] pkt_cnt2,
  output logic                 busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 route_q, route_d;
  logic                 v1_q, v1_d, v2_q, v2_d;
  logic                 l1_q, l1_d, l2_q, l2_d;
  logic [WIDTH-1:0]     d1_q, d1_d, d2_q, d2_d;
  logic [CNT_WIDTH-1:0] c1_q, c1_d, c2_q, c2_d;

  logic             target;
  logic             accept;
  logic             load1, load2;
  logic [WIDTH-1:0] in_data_eff;

`ifdef STREAM_DEMUX2_INVERT_EN
  assign in_data_eff = ~in_data;
`else
  assign in_data_eff = in_data;
`endif

  // Route is only re-evaluated from IDLE; mid-packet beats follow the latched route.
  assign target   = (state_q == BUSY) ? route_q : sel;
  assign in_ready = target ? (~v2_q | out2_ready) : (~v1_q | out1_ready);
  assign accept   = in_valid & in_ready;
  assign load1    = accept & ~target;
  assign load2    = accept & target;

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (accept) begin
      if (state_q == IDLE) begin
        if (!in_last) begin
          state_d = BUSY;
          route_d = sel;
        end
      end else if (in_last) begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    v1_d = v1_q;
    l1_d = l1_q;
    d1_d = d1_q;
    c1_d = c1_q;
    if (v1_q && out1_ready) v1_d = 1'b0;
    if (load1) begin
      v1_d = 1'b1;
      l1_d = in_last;
      d1_d = in_data_eff;
      if (in_last) c1_d = c1_q + 1'b1;
    end
  end

  always_comb begin
    v2_d = v2_q;
    l2_d = l2_q;
    d2_d = d2_q;
    c2_d = c2_q;
    if (v2_q && out2_ready) v2_d = 1'b0;
    if (load2) begin
      v2_d = 1'b1;
      l2_d = in_last;
      d2_d = in_data_eff;
      if (in_last) c2_d = c2_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= 1'b0;
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      d1_q    <= '0;
      c1_q    <= '0;
      v2_q    <= 1'b0;
      l2_q    <= 1'b0;
      d2_q    <= '0;
      c2_q    <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      v1_q    <= v1_d;
      l1_q    <= l1_d;
      d1_q    <= d1_d;
      c1_q    <= c1_d;
      v2_q    <= v2_d;
      l2_q    <= l2_d;
      d2_q    <= d2_d;
      c2_q    <= c2_d;
    end
  end

  assign out1_valid = v1_q;
  assign out1_data  = d1_q;
  assign out1_last  = l1_q;
  assign out2_valid = v2_q;
  assign out2_data  = d2_q;
  assign out2_last  = l2_q;
  assign pkt_cnt1   = c1_q;
  assign pkt_cnt2   = c2_q;
  assign busy       = (state_q == BUSY);

endmodule

// File: tb/tb_stream_demux2.sv
// Directed bench for stream_demux2 (WIDTH=8, CNT_WIDTH=2 so counter wrap is reachable quickly).
module tb_stream_demux2;

  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last, sel;
  logic [W-1:0]  in_data;
  logic          out1_valid, out1_ready, out1_last;
  logic [W-1:0]  out1_data;
  logic          out2_valid, out2_ready, out2_last;
  logic [W-1:0]  out2_data;
  logic [CW-1:0] pkt_cnt1, pkt_cnt2;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int exp_c1 = 0;
  int exp_c2 = 0;

  stream_demux2 #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .sel(sel),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data), .out1_last(out1_last),
    .out2_valid(out2_valid), .out2_ready(out2_ready), .out2_data(out2_data), .out2_last(out2_last),
    .pkt_cnt1(pkt_cnt1), .pkt_cnt2(pkt_cnt2), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] xd(input logic [W-1:0] d);
`ifdef STREAM_DEMUX2_INVERT_EN
    return ~d;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic s, input logic l);
    in_valid = v;
    in_data  = d;
    sel      = s;
    in_last  = l;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; sel = 1'b0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    tick(); tick();
    chk("rst_v1", 32'(out1_valid), 32'd0);
    chk("rst_v2", 32'(out2_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt1", 32'(pkt_cnt1), 32'd0);
    chk("rst_cnt2", 32'(pkt_cnt2), 32'd0);
    rst = 1'b0;
    tick();

    // Single-beat packets to each channel.
    drive(1'b1, 8'hA5, 1'b0, 1'b1);
    chk("sb_ready", 32'(in_ready), 32'd1);
    tick(); exp_c1++;
    chk("sb_v1", 32'(out1_valid), 32'd1);
    chk("sb_d1", 32'(out1_data), 32'(xd(8'hA5)));
    chk("sb_l1", 32'(out1_last), 32'd1);
    chk("sb_v2_idle", 32'(out2_valid), 32'd0);
    chk("sb_cnt1", 32'(pkt_cnt1), 32'(exp_c1 % 4));
    drive(1'b1, 8'h3C, 1'b1, 1'b1);
    tick(); exp_c2++;
    chk("sb_v2", 32'(out2_valid), 32'd1);
    chk("sb_d2", 32'(out2_data), 32'(xd(8'h3C)));
    chk("sb_cnt2", 32'(pkt_cnt2), 32'(exp_c2 % 4));
    chk("sb_v1_drained", 32'(out1_valid), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("sb_v2_drained", 32'(out2_valid), 32'd0);

    // Route hold across a 4-beat packet with sel toggling.
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    tick();
    chk("rh_d1", 32'(out1_data), 32'(xd(8'h01)));
    chk("rh_busy1", 32'(busy), 32'd1);
    chk("rh_last1", 32'(out1_last), 32'd0);
    drive(1'b1, 8'h02, 1'b1, 1'b0);
    chk("rh_ready2", 32'(in_ready), 32'd1);
    tick();
    chk("rh_d2", 32'(out1_data), 32'(xd(8'h02)));
    chk("rh_v2ch", 32'(out2_valid), 32'd0);
    chk("rh_busy2", 32'(busy), 32'd1);
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    tick();
    chk("rh_d3", 32'(out1_data), 32'(xd(8'h03)));
    drive(1'b1, 8'h04, 1'b1, 1'b1);
    tick(); exp_c1++;
    chk("rh_d4", 32'(out1_data), 32'(xd(8'h04)));
    chk("rh_last4", 32'(out1_last), 32'd1);
    chk("rh_busy_end", 32'(busy), 32'd0);
    chk("rh_v2ch_end", 32'(out2_valid), 32'd0);
    chk("rh_cnt1", 32'(pkt_cnt1), 32'(exp_c1 % 4));
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // Back-pressure on out1 must not block out2.
    out1_ready = 1'b0;
    drive(1'b1, 8'h11, 1'b0, 1'b1);
    tick(); exp_c1++;
    chk("bp_v1", 32'(out1_valid), 32'd1);
    chk("bp_d1", 32'(out1_data), 32'(xd(8'h11)));
    drive(1'b1, 8'h22, 1'b0, 1'b1);
    chk("bp_ready_blk", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold_d1", 32'(out1_data), 32'(xd(8'h11)));
    chk("bp_cnt1", 32'(pkt_cnt1), 32'(exp_c1 % 4));
    drive(1'b1, 8'h33, 1'b1, 1'b1);
    chk("bp_ready_other", 32'(in_ready), 32'd1);
    tick(); exp_c2++;
    chk("bp_v2", 32'(out2_valid), 32'd1);
    chk("bp_d2", 32'(out2_data), 32'(xd(8'h33)));
    chk("bp_cnt2", 32'(pkt_cnt2), 32'(exp_c2 % 4));
    chk("bp_v1_held", 32'(out1_valid), 32'd1);
    chk("bp_d1_held", 32'(out1_data), 32'(xd(8'h11)));
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    out1_ready = 1'b1;
    tick();
    chk("bp_v1_drain", 32'(out1_valid), 32'd0);

    // Back-to-back single-beat packets on out2, counter wraps modulo 4.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h50 + i), 1'b1, 1'b1);
      chk("tp_ready", 32'(in_ready), 32'd1);
      tick(); exp_c2++;
      chk("tp_v2", 32'(out2_valid), 32'd1);
      chk("tp_d2", 32'(out2_data), 32'(xd(8'(8'h50 + i))));
      chk("tp_cnt2", 32'(pkt_cnt2), 32'(exp_c2 % 4));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // Asynchronous reset mid-packet, then route a fresh packet to out2.
    out1_ready = 1'b0;
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    chk("ar_busy_pre", 32'(busy), 32'd1);
    chk("ar_v1_pre", 32'(out1_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_v1", 32'(out1_valid), 32'd0);
    chk("ar_d1", 32'(out1_data), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_cnt1", 32'(pkt_cnt1), 32'd0);
    chk("ar_cnt2", 32'(pkt_cnt2), 32'd0);
    exp_c1 = 0; exp_c2 = 0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    out1_ready = 1'b1;
    drive(1'b1, 8'h88, 1'b1, 1'b1);
    chk("ar_ready", 32'(in_ready), 32'd1);
    tick(); exp_c2++;
    chk("ar_v2", 32'(out2_valid), 32'd1);
    chk("ar_d2", 32'(out2_data), 32'(xd(8'h88)));
    chk("ar_v1_post", 32'(out1_valid), 32'd0);
    chk("ar_cnt2_post", 32'(pkt_cnt2), 32'(exp_c2 % 4));
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
